// File: rtl/jvs_feature_parser_pkg.sv
// Shared JVS definitions for the feature-check parser.
// Contents:
//   - JVS_FEATURE_* function codes from the feature-check reply.
//   - JVS_COIN_MAX, the cap on the reported coin slot count.
//   - jvs_caps_t, the per-node capability record.
//   - jvs_node_info_t, the per-node record kept by the top level.
//   - The parser state encoding and small decode helpers.
package jvs_feature_parser_pkg;

  localparam logic [7:0] JVS_FEATURE_PLAYERS     = 8'h01;
  localparam logic [7:0] JVS_FEATURE_COINS       = 8'h02;
  localparam logic [7:0] JVS_FEATURE_ANALOG_IN   = 8'h03;
  localparam logic [7:0] JVS_FEATURE_ROTARY      = 8'h04;
  localparam logic [7:0] JVS_FEATURE_KEYCODE     = 8'h05;
  localparam logic [7:0] JVS_FEATURE_SCREEN_POS  = 8'h06;
  localparam logic [7:0] JVS_FEATURE_MISC_DIG    = 8'h07;
  localparam logic [7:0] JVS_FEATURE_CARD        = 8'h10;
  localparam logic [7:0] JVS_FEATURE_HOPPER      = 8'h11;
  localparam logic [7:0] JVS_FEATURE_DIGITAL_OUT = 8'h12;
  localparam logic [7:0] JVS_FEATURE_ANALOG_OUT  = 8'h13;
  localparam logic [7:0] JVS_FEATURE_CHAR_DISP   = 8'h14;
  localparam logic [7:0] JVS_FEATURE_BACKUP      = 8'h15;

  localparam int unsigned JVS_COIN_MAX = 4;

  // Coin slot count is a 4-bit field, so the effective cap is the smaller
  // of JVS_COIN_MAX and 15.
  localparam logic [7:0] JVS_COIN_LIMIT =
    (JVS_COIN_MAX < 15) ? 8'(JVS_COIN_MAX) : 8'd15;

  typedef struct packed {
    logic [3:0]  players;
    logic [7:0]  buttons;
    logic [3:0]  coin_slots;
    logic [3:0]  analog_ch;
    logic [7:0]  analog_bits;
    logic [3:0]  rotary_ch;
    logic        keycode;
    logic        screen_pos;
    logic [7:0]  spos_x_bits;
    logic [7:0]  spos_y_bits;
    logic [7:0]  spos_ch;
    logic [15:0] misc_digital;
    logic [7:0]  card_slots;
    logic [7:0]  hopper_ch;
    logic [7:0]  digital_out;
    logic [3:0]  analog_out_ch;
    logic        char_disp;
    logic [7:0]  cd_width;
    logic [7:0]  cd_height;
    logic [7:0]  cd_type;
    logic        backup;
  } jvs_caps_t;

  typedef struct packed {
    logic      present;
    jvs_caps_t caps;
  } jvs_node_info_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CODE,
    ST_P1,
    ST_P2,
    ST_P3,
    ST_DRAIN,
    ST_DONE
  } state_t;

  // Clamp a payload byte into a 4-bit field; lim must be <= 15.
  function automatic logic [3:0] sat4(input logic [7:0] v, input logic [7:0] lim);
    return (v > lim) ? lim[3:0] : v[3:0];
  endfunction

  function automatic logic is_known_code(input logic [7:0] code);
    return code inside {JVS_FEATURE_PLAYERS, JVS_FEATURE_COINS,
                        JVS_FEATURE_ANALOG_IN, JVS_FEATURE_ROTARY,
                        JVS_FEATURE_KEYCODE, JVS_FEATURE_SCREEN_POS,
                        JVS_FEATURE_MISC_DIG, JVS_FEATURE_CARD,
                        JVS_FEATURE_HOPPER, JVS_FEATURE_DIGITAL_OUT,
                        JVS_FEATURE_ANALOG_OUT, JVS_FEATURE_CHAR_DISP,
                        JVS_FEATURE_BACKUP};
  endfunction

endpackage

// File: rtl/jvs_feature_parser_if.sv
// Byte-stream interface carrying the feature-check payload into the parser.
//   s_valid : payload byte valid (master -> slave)
//   s_data  : payload byte (master -> slave)
//   s_last  : final payload byte of the packet (master -> slave)
//   s_ready : parser can accept a byte (slave -> master)
interface jvs_feature_parser_if;
  logic       s_valid;
  logic [7:0] s_data;
  logic       s_last;
  logic       s_ready;

  modport master (output s_valid, output s_data, output s_last, input s_ready);
  modport slave  (input s_valid, input s_data, input s_last, output s_ready);
endinterface

// File: rtl/jvs_feature_parser.sv
// JVS feature-check payload parser.
// Walks the 4-byte {code, p1, p2, p3} records of a feature-check reply and
// builds a capability record for one node. The final record is reported with
// a one-cycle done pulse; the results are held until the next start.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   start      : one-cycle pulse, clears results and begins a parse
//   node_idx   : node the payload belongs to, latched on start
//   s          : payload byte stream (slave side)
//   busy       : parser not idle
//   done       : one-cycle completion pulse
//   err        : packet ended before the 0x00 terminator
//   unk        : at least one unknown function code was seen
//   out_idx    : latched node_idx
//   caps       : parsed capability record
module jvs_feature_parser
  import jvs_feature_parser_pkg::*;
#(
  parameter  int MAX_JVS_NODES = 2,
  localparam int NIB = (MAX_JVS_NODES > 1) ? $clog2(MAX_JVS_NODES) : 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [NIB-1:0]         node_idx,
  jvs_feature_parser_if.slave    s,
  output logic                   busy,
  output logic                   done,
  output logic                   err,
  output logic                   unk,
  output logic [NIB-1:0]         out_idx,
  output jvs_caps_t              caps
);

  state_t     state_q, state_d;
  logic [7:0] code_q, p1_q, p2_q;
  jvs_caps_t  caps_q, caps_commit;
  logic       err_q, unk_q;
  logic [NIB-1:0] idx_q;
  logic       accept;

  assign s.s_ready = (state_q inside {ST_CODE, ST_P1, ST_P2, ST_P3, ST_DRAIN});
  assign accept    = s.s_valid && s.s_ready;
  assign busy      = (state_q != ST_IDLE);
  assign done      = (state_q == ST_DONE);
  assign err       = err_q;
  assign unk       = unk_q;
  assign out_idx   = idx_q;
  assign caps      = caps_q;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // NOTE: every output of this block gets a default first; a path that left
  // one unassigned would infer a latch.
  always_comb begin
    state_d = state_q;
    if (start) begin
      state_d = ST_CODE;
    end else begin
      unique case (state_q)
        ST_IDLE:  state_d = ST_IDLE;
        ST_CODE:
          if (accept) begin
            if (s.s_data == 8'h00) state_d = s.s_last ? ST_DONE : ST_DRAIN;
            else                   state_d = s.s_last ? ST_DONE : ST_P1;
          end
        ST_P1:    if (accept) state_d = s.s_last ? ST_DONE : ST_P2;
        ST_P2:    if (accept) state_d = s.s_last ? ST_DONE : ST_P3;
        ST_P3:    if (accept) state_d = s.s_last ? ST_DONE : ST_CODE;
        ST_DRAIN: if (accept && s.s_last) state_d = ST_DONE;
        ST_DONE:  state_d = ST_IDLE;
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  // Record commit decode. p3 is taken straight from the bus so the record
  // lands in caps on the same edge that accepts its third parameter.
  always_comb begin
    caps_commit = caps_q;
    unique case (code_q)
      JVS_FEATURE_PLAYERS: begin
        caps_commit.players = sat4(p1_q, 8'd15);
        caps_commit.buttons = p2_q;
      end
      JVS_FEATURE_COINS:   caps_commit.coin_slots = sat4(p1_q, JVS_COIN_LIMIT);
      JVS_FEATURE_ANALOG_IN: begin
        caps_commit.analog_ch   = sat4(p1_q, 8'd15);
        caps_commit.analog_bits = p2_q;
      end
      JVS_FEATURE_ROTARY:  caps_commit.rotary_ch = sat4(p1_q, 8'd15);
      JVS_FEATURE_KEYCODE: caps_commit.keycode = 1'b1;
      JVS_FEATURE_SCREEN_POS: begin
        caps_commit.screen_pos  = 1'b1;
        caps_commit.spos_x_bits = p1_q;
        caps_commit.spos_y_bits = p2_q;
        caps_commit.spos_ch     = s.s_data;
      end
      JVS_FEATURE_MISC_DIG:    caps_commit.misc_digital = {p1_q, p2_q};
      JVS_FEATURE_CARD:        caps_commit.card_slots = p1_q;
      JVS_FEATURE_HOPPER:      caps_commit.hopper_ch = p1_q;
      JVS_FEATURE_DIGITAL_OUT: caps_commit.digital_out = p1_q;
      JVS_FEATURE_ANALOG_OUT:  caps_commit.analog_out_ch = sat4(p1_q, 8'd15);
      JVS_FEATURE_CHAR_DISP: begin
        caps_commit.char_disp = 1'b1;
        caps_commit.cd_width  = p1_q;
        caps_commit.cd_height = p2_q;
        caps_commit.cd_type   = s.s_data;
      end
      JVS_FEATURE_BACKUP:      caps_commit.backup = 1'b1;
      default:                 caps_commit = caps_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      code_q <= '0;
      p1_q   <= '0;
      p2_q   <= '0;
      caps_q <= '0;
      err_q  <= 1'b0;
      unk_q  <= 1'b0;
      idx_q  <= '0;
    end else if (start) begin
      caps_q <= '0;
      err_q  <= 1'b0;
      unk_q  <= 1'b0;
      idx_q  <= node_idx;
    end else if (accept) begin
      unique case (state_q)
        ST_CODE:
          if (s.s_data != 8'h00) begin
            code_q <= s.s_data;
            if (!is_known_code(s.s_data)) unk_q <= 1'b1;
            if (s.s_last)                 err_q <= 1'b1;
          end
        ST_P1: begin
          p1_q <= s.s_data;
          if (s.s_last) err_q <= 1'b1;
        end
        ST_P2: begin
          p2_q <= s.s_data;
          if (s.s_last) err_q <= 1'b1;
        end
        ST_P3:
          // A truncated record is dropped; unknown codes never commit.
          if (s.s_last)                   err_q  <= 1'b1;
          else if (is_known_code(code_q)) caps_q <= caps_commit;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_jvs_feature_parser.sv
// Self-checking bench for jvs_feature_parser: directed payloads followed by
// random packets compared against a record-level reference model.
module tb_jvs_feature_parser;
  import jvs_feature_parser_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [0:0] node_idx;
  logic       busy, done, err, unk;
  logic [0:0] out_idx;
  jvs_caps_t  caps;

  jvs_feature_parser_if bus ();

  jvs_feature_parser #(.MAX_JVS_NODES(2)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .node_idx (node_idx),
    .s        (bus),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .unk      (unk),
    .out_idx  (out_idx),
    .caps     (caps)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fails  = 0;

  logic [7:0] known_codes [13] = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06,
                                   8'h07, 8'h10, 8'h11, 8'h12, 8'h13, 8'h14,
                                   8'h15};

  task automatic check(input string tag, input logic [255:0] obs,
                       input logic [255:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] clamp(input int v, input int m);
    return 4'((v > m) ? m : v);
  endfunction

  function automatic logic tb_known(input logic [7:0] c);
    foreach (known_codes[i]) if (known_codes[i] == c) return 1'b1;
    return 1'b0;
  endfunction

  // Reference model: walks the payload one whole record at a time.
  function automatic void model(input logic [7:0] pkt[$], output jvs_caps_t c,
                                output logic e, output logic u);
    int n = pkt.size();
    int pos = 0;
    int coin_cap = (JVS_COIN_MAX < 15) ? int'(JVS_COIN_MAX) : 15;
    logic [7:0] code, a, b, d;
    c = '0; e = 1'b0; u = 1'b0;
    while (pos < n) begin
      code = pkt[pos];
      if (code == 8'h00) break;
      if (!tb_known(code)) u = 1'b1;
      if (pos + 3 >= n - 1) begin
        e = 1'b1;
        break;
      end
      a = pkt[pos+1]; b = pkt[pos+2]; d = pkt[pos+3];
      case (code)
        8'h01: begin c.players = clamp(a, 15); c.buttons = b; end
        8'h02: c.coin_slots = clamp(a, coin_cap);
        8'h03: begin c.analog_ch = clamp(a, 15); c.analog_bits = b; end
        8'h04: c.rotary_ch = clamp(a, 15);
        8'h05: c.keycode = 1'b1;
        8'h06: begin
          c.screen_pos = 1'b1; c.spos_x_bits = a; c.spos_y_bits = b; c.spos_ch = d;
        end
        8'h07: c.misc_digital = {a, b};
        8'h10: c.card_slots = a;
        8'h11: c.hopper_ch = a;
        8'h12: c.digital_out = a;
        8'h13: c.analog_out_ch = clamp(a, 15);
        8'h14: begin
          c.char_disp = 1'b1; c.cd_width = a; c.cd_height = b; c.cd_type = d;
        end
        8'h15: c.backup = 1'b1;
        default: ;
      endcase
      pos += 4;
    end
  endfunction

  // Called at a negedge; leaves at a negedge.
  task automatic do_start(input logic [0:0] idx);
    start = 1'b1;
    node_idx = idx;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Sends bytes at negedges; returns at the negedge following the edge that
  // accepted the final byte.
  task automatic send_pkt(input logic [7:0] pkt[$], input bit mark_last,
                          input int max_gap);
    int guard;
    for (int i = 0; i < pkt.size(); i++) begin
      repeat ($urandom_range(0, max_gap)) @(negedge clk);
      guard = 0;
      while (!bus.s_ready && guard < 20) begin
        @(negedge clk);
        guard++;
      end
      if (!bus.s_ready) begin
        check("ready_timeout", 256'(bus.s_ready), 256'(1));
        return;
      end
      bus.s_valid = 1'b1;
      bus.s_data  = pkt[i];
      bus.s_last  = mark_last && (i == pkt.size() - 1);
      @(negedge clk);
      bus.s_valid = 1'b0;
      bus.s_last  = 1'b0;
    end
  endtask

  task automatic check_result(input string tag, input jvs_caps_t exp_caps,
                              input logic exp_err, input logic exp_unk,
                              input logic [0:0] exp_idx);
    check({tag, ".done"},    256'(done),    256'(1));
    check({tag, ".caps"},    256'(caps),    256'(exp_caps));
    check({tag, ".err"},     256'(err),     256'(exp_err));
    check({tag, ".unk"},     256'(unk),     256'(exp_unk));
    check({tag, ".out_idx"}, 256'(out_idx), 256'(exp_idx));
    @(negedge clk);
    check({tag, ".done_clr"},  256'(done), 256'(0));
    check({tag, ".idle"},      256'(busy), 256'(0));
    check({tag, ".caps_hold"}, 256'(caps), 256'(exp_caps));
  endtask

  initial begin
    logic [7:0] q[$];
    jvs_caps_t  ec;
    logic       ee, eu;
    logic [0:0] idx;
    int         nrec, tail, k;
    logic [7:0] code;

    rst_n = 1'b0; start = 1'b0; node_idx = '0;
    bus.s_valid = 1'b0; bus.s_data = '0; bus.s_last = 1'b0;
    #1;
    check("rst.busy",    256'(busy),        256'(0));
    check("rst.done",    256'(done),        256'(0));
    check("rst.s_ready", 256'(bus.s_ready), 256'(0));
    check("rst.caps",    256'(caps),        256'(0));
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Two-player, 13-button, two coin slots.
    do_start(1'b0);
    check("start.busy", 256'(busy), 256'(1));
    q = '{8'h01, 8'h02, 8'h0D, 8'h00, 8'h02, 8'h02, 8'h00, 8'h00, 8'h00};
    send_pkt(q, 1'b1, 0);
    ec = '0; ec.players = 4'd2; ec.buttons = 8'd13; ec.coin_slots = 4'd2;
    check_result("basic", ec, 1'b0, 1'b0, 1'b0);

    // Analog, screen position and misc digital.
    do_start(1'b0);
    q = '{8'h03, 8'h08, 8'h0A, 8'h00, 8'h06, 8'h10, 8'h10, 8'h01,
          8'h07, 8'h01, 8'h02, 8'h00, 8'h00};
    send_pkt(q, 1'b1, 2);
    ec = '0; ec.analog_ch = 4'd8; ec.analog_bits = 8'd10; ec.screen_pos = 1'b1;
    ec.spos_x_bits = 8'd16; ec.spos_y_bits = 8'd16; ec.spos_ch = 8'd1;
    ec.misc_digital = 16'h0102;
    check_result("analog", ec, 1'b0, 1'b0, 1'b0);

    // Saturation of players and coin slots.
    do_start(1'b0);
    q = '{8'h01, 8'h20, 8'h05, 8'h00, 8'h02, 8'h09, 8'h00, 8'h00, 8'h00};
    send_pkt(q, 1'b1, 0);
    ec = '0; ec.players = 4'd15; ec.buttons = 8'd5; ec.coin_slots = 4'd4;
    check_result("sat", ec, 1'b0, 1'b0, 1'b0);

    // Truncated record.
    do_start(1'b0);
    q = '{8'h01, 8'h02};
    send_pkt(q, 1'b1, 0);
    check_result("trunc", '0, 1'b1, 1'b0, 1'b0);

    // Unknown code then terminator with trailing bytes.
    do_start(1'b0);
    q = '{8'h7F, 8'h01, 8'h02, 8'h03, 8'h00};
    send_pkt(q, 1'b0, 0);
    check("drain.busy", 256'(busy), 256'(1));
    check("drain.done", 256'(done), 256'(0));
    q = '{8'hAA, 8'hBB};
    send_pkt(q, 1'b1, 1);
    check_result("unknown", '0, 1'b0, 1'b1, 1'b0);

    // Restart mid-record on node 1.
    do_start(1'b0);
    q = '{8'h01, 8'h05};
    send_pkt(q, 1'b0, 0);
    do_start(1'b1);
    q = '{8'h02, 8'h01, 8'h00, 8'h00, 8'h00};
    send_pkt(q, 1'b1, 0);
    ec = '0; ec.coin_slots = 4'd1;
    check_result("restart", ec, 1'b0, 1'b0, 1'b1);

    // Reset mid-packet after a committed record.
    do_start(1'b1);
    q = '{8'h02, 8'h03, 8'h00, 8'h00, 8'h01};
    send_pkt(q, 1'b0, 0);
    check("pre_rst.caps", 256'(caps.coin_slots), 256'(3));
    rst_n = 1'b0;
    #1;
    check("mid_rst.busy",    256'(busy),        256'(0));
    check("mid_rst.s_ready", 256'(bus.s_ready), 256'(0));
    check("mid_rst.caps",    256'(caps),        256'(0));
    check("mid_rst.out_idx", 256'(out_idx),     256'(0));
    check("mid_rst.flags",   256'({done, err, unk}), 256'(0));
    @(negedge clk);
    rst_n = 1'b1;
    // Bytes presented without a start are ignored.
    bus.s_valid = 1'b1; bus.s_data = 8'h01; bus.s_last = 1'b1;
    repeat (4) @(negedge clk);
    bus.s_valid = 1'b0; bus.s_last = 1'b0;
    check("nostart.busy", 256'(busy), 256'(0));
    check("nostart.done", 256'(done), 256'(0));
    check("nostart.caps", 256'(caps), 256'(0));

    // Random packets.
    for (int t = 0; t < 40; t++) begin
      q = {};
      nrec = $urandom_range(0, 5);
      for (int r = 0; r < nrec; r++) begin
        if ($urandom_range(0, 15) < 13) code = known_codes[$urandom_range(0, 12)];
        else                            code = 8'($urandom_range(8'h20, 8'hFE));
        q.push_back(code);
        for (int p = 0; p < 3; p++)
          q.push_back($urandom_range(0, 1) ? 8'($urandom_range(0, 31))
                                           : 8'($urandom_range(0, 255)));
      end
      tail = $urandom_range(0, 3);
      if (tail == 2 && nrec > 0) begin
        k = $urandom_range(1, 3);
        repeat (k) void'(q.pop_back());
      end else begin
        q.push_back(8'h00);
        if (tail == 1)
          repeat ($urandom_range(1, 3)) q.push_back(8'($urandom_range(0, 255)));
      end
      idx = 1'($urandom_range(0, 1));
      model(q, ec, ee, eu);
      do_start(idx);
      send_pkt(q, 1'b1, 2);
      check_result($sformatf("rand%0d", t), ec, ee, eu, idx);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
